// File: rtl/serializer_pkg.sv
// Constants shared by the parallelizer and serializer, plus the serializer state encoding.
// No logic; widths derived here so both directions of the datapath agree.
// Index and counter widths are floored at 1 so degenerate configurations still elaborate.
package serializer_pkg;

    localparam int ENCRYPTER_WIDTH          = 64;
    localparam int NUM_ENCRYPTERS           = 4;
    localparam int ENCRYPTER_QSPI_COUNT     = ENCRYPTER_WIDTH / 4;
    localparam int NUM_ENCRYPTERS_REG       = (NUM_ENCRYPTERS > 1) ? $clog2(NUM_ENCRYPTERS) : 1;
    localparam int ENCRYPTER_QSPI_COUNT_REG = (ENCRYPTER_QSPI_COUNT > 1) ? $clog2(ENCRYPTER_QSPI_COUNT) : 1;

    typedef enum logic {
        WAIT  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/nibble_shifter.sv
// Parallel-load register that presents its top nibble and shifts left by 4 per accepted nibble.
// Latency: loaded word visible on nibble the cycle after load; one nibble per shift cycle.
// Backpressure: holds nibble and count whenever shift is low.
module nibble_shifter
    import serializer_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [ENCRYPTER_WIDTH-1:0] load_data,
    input  logic                       shift,
    output logic [3:0]                 nibble,
    output logic                       last_nibble
);

    localparam logic [ENCRYPTER_QSPI_COUNT_REG-1:0] LAST_COUNT =
        ENCRYPTER_QSPI_COUNT_REG'(ENCRYPTER_QSPI_COUNT - 1);

    logic [ENCRYPTER_WIDTH-1:0]          shift_reg;
    logic [ENCRYPTER_QSPI_COUNT_REG-1:0] count;

    // A fully shifted word leaves zeros behind, so nibble reads 0 once the packet is done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            count     <= '0;
        end else if (load) begin
            shift_reg <= load_data;
            count     <= '0;
        end else if (shift) begin
            shift_reg <= {shift_reg[ENCRYPTER_WIDTH-5:0], 4'b0000};
            count     <= last_nibble ? '0 : count + ENCRYPTER_QSPI_COUNT_REG'(1);
        end
    end

    assign nibble      = shift_reg[ENCRYPTER_WIDTH-1 -: 4];
    assign last_nibble = (count == LAST_COUNT);

endmodule

// File: rtl/serializer.sv
// Collects ciphertext from the encrypters in strict round-robin order and streams it as QSPI nibbles, MSB first.
// Latency: valid sampled at edge N gives ack and first nibble in cycle N+1; at least one WAIT cycle between packets.
// Backpressure: qspi_ready low holds the current nibble indefinitely; other encrypters wait for their turn.
module serializer
    import serializer_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_ENCRYPTERS*ENCRYPTER_WIDTH-1:0] encrypters_data,
    input  logic [NUM_ENCRYPTERS-1:0]                 encrypters_data_valid,
    output logic [NUM_ENCRYPTERS-1:0]                 encrypters_ack,
    output logic [3:0]                                qspi_data,
    output logic                                      qspi_sending,
    input  logic                                      qspi_ready,
    output logic                                      busy,
    output logic [NUM_ENCRYPTERS_REG-1:0]             encrypter_index_out
);

    localparam logic [NUM_ENCRYPTERS_REG-1:0] LAST_IDX = NUM_ENCRYPTERS_REG'(NUM_ENCRYPTERS - 1);

    state_t                         state, next_state;
    logic [NUM_ENCRYPTERS_REG-1:0]  index, next_index;
    logic [NUM_ENCRYPTERS-1:0]      ack_d;
    logic [ENCRYPTER_WIDTH-1:0]     sel_data;
    logic                           load, shift, last_nibble;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= WAIT;
            index          <= '0;
            encrypters_ack <= '0;
        end else begin
            state          <= next_state;
            index          <= next_index;
            encrypters_ack <= ack_d;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_ENCRYPTERS; i++) begin
            if (index == NUM_ENCRYPTERS_REG'(i)) begin
                sel_data = encrypters_data[i*ENCRYPTER_WIDTH +: ENCRYPTER_WIDTH];
            end
        end
    end

    // Only the encrypter whose turn it is can start a packet; the index moves only after its last nibble.
    always_comb begin
        next_state = state;
        next_index = index;
        ack_d      = '0;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            WAIT: begin
                if (encrypters_data_valid[index]) begin
                    load         = 1'b1;
                    ack_d[index] = 1'b1;
                    next_state   = SHIFT;
                end
            end
            SHIFT: begin
                if (qspi_ready) begin
                    shift = 1'b1;
                    if (last_nibble) begin
                        next_state = WAIT;
                        next_index = (index == LAST_IDX) ? '0 : index + NUM_ENCRYPTERS_REG'(1);
                    end
                end
            end
        endcase
    end

    nibble_shifter u_nibble_shifter (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_data   (sel_data),
        .shift       (shift),
        .nibble      (qspi_data),
        .last_nibble (last_nibble)
    );

    assign qspi_sending        = (state == SHIFT);
    assign busy                = (state == SHIFT);
    assign encrypter_index_out = index;

endmodule

// File: tb/tb_serializer.sv
// Directed bench for the serializer: round-robin order, nibble order, backpressure, async reset, capture timing.
module tb_serializer;

    logic         clk;
    logic         reset;
    logic [255:0] encrypters_data;
    logic [3:0]   encrypters_data_valid;
    logic [3:0]   encrypters_ack;
    logic [3:0]   qspi_data;
    logic         qspi_sending;
    logic         qspi_ready;
    logic         busy;
    logic [1:0]   encrypter_index_out;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] got;
        int          nibs;
        int          cyc;
        logic [3:0]  first_ack;
        int          ack_cycles;
        int          wait_cyc;
        logic        first_busy;
        bit          timeout;
    } pkt_t;

    serializer dut (
        .clk                   (clk),
        .reset                 (reset),
        .encrypters_data       (encrypters_data),
        .encrypters_data_valid (encrypters_data_valid),
        .encrypters_ack        (encrypters_ack),
        .qspi_data             (qspi_data),
        .qspi_sending          (qspi_sending),
        .qspi_ready            (qspi_ready),
        .busy                  (busy),
        .encrypter_index_out   (encrypter_index_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset                 = 1'b1;
        encrypters_data_valid = '0;
        encrypters_data       = '0;
        qspi_ready            = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // Observes one packet; ready pattern is 1,0,0 repeating when toggle is set.
    task automatic collect(input bit toggle, output pkt_t p);
        int guard;
        int j;
        p.got = '0; p.nibs = 0; p.cyc = 0; p.first_ack = '0;
        p.ack_cycles = 0; p.wait_cyc = 0; p.first_busy = 1'b0; p.timeout = 1'b0;
        guard = 0;
        while (qspi_sending !== 1'b1 && guard < 40) begin
            step();
            guard++;
        end
        p.wait_cyc = guard;
        if (qspi_sending !== 1'b1) begin
            p.timeout = 1'b1;
            return;
        end
        p.first_ack  = encrypters_ack;
        p.first_busy = busy;
        j = 0;
        while (qspi_sending === 1'b1 && j < 200) begin
            if (encrypters_ack != 4'b0000) p.ack_cycles++;
            qspi_ready = toggle ? (j % 3 == 0) : 1'b1;
            if (qspi_ready) begin
                p.got = {p.got[59:0], qspi_data};
                p.nibs++;
            end
            j++;
            step();
        end
        p.cyc      = j;
        qspi_ready = 1'b1;
        if (qspi_sending === 1'b1) p.timeout = 1'b1;
    endtask

    task automatic test_reset();
        reset                 = 1'b1;
        encrypters_data       = {4{64'h0123456789ABCDEF}};
        encrypters_data_valid = 4'hF;
        qspi_ready            = 1'b1;
        step();
        step();
        tests++; if (encrypters_ack !== 4'b0000) begin fails++; $display("FAIL reset_ack: got %b expected 0000", encrypters_ack); end
        tests++; if (qspi_data !== 4'h0) begin fails++; $display("FAIL reset_qspi_data: got %h expected 0", qspi_data); end
        tests++; if (qspi_sending !== 1'b0) begin fails++; $display("FAIL reset_sending: got %b expected 0", qspi_sending); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (encrypter_index_out !== 2'd0) begin fails++; $display("FAIL reset_index: got %0d expected 0", encrypter_index_out); end
    endtask

    task automatic test_single();
        pkt_t p;
        do_reset();
        encrypters_data[63:0] = 64'h0123456789ABCDEF;
        encrypters_data_valid = 4'b0001;
        collect(1'b0, p);
        encrypters_data_valid = 4'b0000;
        tests++; if (p.timeout !== 1'b0) begin fails++; $display("FAIL single_timeout: packet did not complete"); end
        tests++; if (p.wait_cyc !== 1) begin fails++; $display("FAIL single_latency: got %0d cycles expected 1", p.wait_cyc); end
        tests++; if (p.first_ack !== 4'b0001) begin fails++; $display("FAIL single_ack: got %b expected 0001", p.first_ack); end
        tests++; if (p.ack_cycles !== 1) begin fails++; $display("FAIL single_ack_width: got %0d cycles expected 1", p.ack_cycles); end
        tests++; if (p.first_busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b expected 1", p.first_busy); end
        tests++; if (p.got !== 64'h0123456789ABCDEF) begin fails++; $display("FAIL single_data: got %h expected 0123456789abcdef", p.got); end
        tests++; if (p.cyc !== 16) begin fails++; $display("FAIL single_sending_cycles: got %0d expected 16", p.cyc); end
        tests++; if (encrypter_index_out !== 2'd1) begin fails++; $display("FAIL single_index: got %0d expected 1", encrypter_index_out); end
        tests++; if (qspi_data !== 4'h0) begin fails++; $display("FAIL single_idle_data: got %h expected 0", qspi_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_all_four();
        pkt_t p;
        logic [63:0] exp_d [4] = '{64'h1111111111111111, 64'h2222222222222222,
                                   64'h3333333333333333, 64'h4444444444444444};
        logic [3:0]  exp_a [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        encrypters_data = {64'h4444444444444444, 64'h3333333333333333,
                           64'h2222222222222222, 64'h1111111111111111};
        for (int r = 0; r < 2; r++) begin
            encrypters_data_valid = 4'hF;
            for (int i = 0; i < 4; i++) begin
                collect(1'b0, p);
                encrypters_data_valid[i] = 1'b0;
                tests++; if (p.got !== exp_d[i]) begin fails++; $display("FAIL rr_data r%0d i%0d: got %h expected %h", r, i, p.got, exp_d[i]); end
                tests++; if (p.first_ack !== exp_a[i]) begin fails++; $display("FAIL rr_ack r%0d i%0d: got %b expected %b", r, i, p.first_ack, exp_a[i]); end
                tests++; if (p.nibs !== 16 || p.timeout) begin fails++; $display("FAIL rr_count r%0d i%0d: got %0d nibbles expected 16", r, i, p.nibs); end
            end
            tests++; if (encrypter_index_out !== 2'd0) begin fails++; $display("FAIL rr_wrap r%0d: got %0d expected 0", r, encrypter_index_out); end
        end
    endtask

    task automatic test_stall();
        pkt_t p;
        int   bad;
        do_reset();
        encrypters_data = {64'h0, 64'hCCCCCCCC00000002, 64'hBBBBBBBB00000001, 64'hAAAAAAAA00000000};
        encrypters_data_valid = 4'b0100;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (qspi_sending !== 1'b0 || encrypters_ack !== 4'b0000) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL stall_no_output: got %0d active cycles expected 0", bad); end
        tests++; if (encrypter_index_out !== 2'd0) begin fails++; $display("FAIL stall_index: got %0d expected 0", encrypter_index_out); end
        encrypters_data_valid = 4'b0111;
        collect(1'b0, p);
        encrypters_data_valid[0] = 1'b0;
        tests++; if (p.got !== 64'hAAAAAAAA00000000 || p.first_ack !== 4'b0001) begin fails++; $display("FAIL stall_first: got %h ack %b expected aaaaaaaa00000000 ack 0001", p.got, p.first_ack); end
        collect(1'b0, p);
        encrypters_data_valid[1] = 1'b0;
        tests++; if (p.got !== 64'hBBBBBBBB00000001 || p.first_ack !== 4'b0010) begin fails++; $display("FAIL stall_second: got %h ack %b expected bbbbbbbb00000001 ack 0010", p.got, p.first_ack); end
        collect(1'b0, p);
        encrypters_data_valid[2] = 1'b0;
        tests++; if (p.got !== 64'hCCCCCCCC00000002 || p.first_ack !== 4'b0100) begin fails++; $display("FAIL stall_third: got %h ack %b expected cccccccc00000002 ack 0100", p.got, p.first_ack); end
        tests++; if (encrypter_index_out !== 2'd3) begin fails++; $display("FAIL stall_end_index: got %0d expected 3", encrypter_index_out); end
    endtask

    task automatic test_backpressure();
        pkt_t p;
        do_reset();
        encrypters_data[63:0] = 64'hFEDCBA9876543210;
        encrypters_data_valid = 4'b0001;
        collect(1'b1, p);
        encrypters_data_valid = 4'b0000;
        tests++; if (p.timeout !== 1'b0) begin fails++; $display("FAIL bp_timeout: packet did not complete"); end
        tests++; if (p.got !== 64'hFEDCBA9876543210) begin fails++; $display("FAIL bp_data: got %h expected fedcba9876543210", p.got); end
        tests++; if (p.nibs !== 16) begin fails++; $display("FAIL bp_nibbles: got %0d expected 16", p.nibs); end
        tests++; if (p.cyc !== 46) begin fails++; $display("FAIL bp_cycles: got %0d expected 46", p.cyc); end
    endtask

    task automatic test_reset_mid();
        pkt_t p;
        do_reset();
        encrypters_data[63:0]   = 64'h13579BDF02468ACE;
        encrypters_data[127:64] = 64'h0123456789ABCDEF;
        encrypters_data_valid   = 4'b0011;
        collect(1'b0, p);
        encrypters_data_valid[0] = 1'b0;
        tests++; if (p.got !== 64'h13579BDF02468ACE) begin fails++; $display("FAIL rmid_first: got %h expected 13579bdf02468ace", p.got); end
        step();
        encrypters_data_valid[1] = 1'b0;
        repeat (7) step();
        tests++; if (qspi_data !== 4'h7 || qspi_sending !== 1'b1) begin fails++; $display("FAIL rmid_pre: got data %h sending %b expected 7 1", qspi_data, qspi_sending); end
        #2;
        reset = 1'b1;
        #1;
        tests++; if (qspi_sending !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rmid_sending: got sending %b busy %b expected 0 0", qspi_sending, busy); end
        tests++; if (qspi_data !== 4'h0) begin fails++; $display("FAIL rmid_data: got %h expected 0", qspi_data); end
        tests++; if (encrypter_index_out !== 2'd0) begin fails++; $display("FAIL rmid_index: got %0d expected 0", encrypter_index_out); end
        tests++; if (encrypters_ack !== 4'b0000) begin fails++; $display("FAIL rmid_ack: got %b expected 0000", encrypters_ack); end
        step();
        reset                 = 1'b0;
        encrypters_data[63:0] = 64'h0123456789ABCDEF;
        encrypters_data_valid = 4'b0001;
        collect(1'b0, p);
        encrypters_data_valid = 4'b0000;
        tests++; if (p.got !== 64'h0123456789ABCDEF || p.nibs !== 16) begin fails++; $display("FAIL rmid_restart: got %h (%0d nibbles) expected 0123456789abcdef (16)", p.got, p.nibs); end
    endtask

    task automatic test_data_change();
        pkt_t p;
        do_reset();
        encrypters_data[63:0] = 64'hA5A55A5AC3C33C3C;
        encrypters_data_valid = 4'b0001;
        fork
            collect(1'b0, p);
            begin
                int g;
                g = 0;
                while (encrypters_ack[0] !== 1'b1 && g < 40) begin
                    step();
                    g++;
                end
                step();
                encrypters_data[63:0] = 64'h0F0F0F0F0F0F0F0F;
                encrypters_data_valid = 4'b0000;
            end
        join
        tests++; if (p.got !== 64'hA5A55A5AC3C33C3C) begin fails++; $display("FAIL capture_data: got %h expected a5a55a5ac3c33c3c", p.got); end
        tests++; if (p.nibs !== 16 || p.timeout) begin fails++; $display("FAIL capture_count: got %0d nibbles expected 16", p.nibs); end
        tests++; if (encrypter_index_out !== 2'd1) begin fails++; $display("FAIL capture_index: got %0d expected 1", encrypter_index_out); end
    endtask

    initial begin
        reset                 = 1'b1;
        encrypters_data       = '0;
        encrypters_data_valid = '0;
        qspi_ready            = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_stall();
        test_backpressure();
        test_reset_mid();
        test_data_change();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
